// File: rtl/mem_stage_pkg.sv
// Shared constants and FSM state type for the MEM pipeline stage.
package mem_stage_pkg;

    localparam int unsigned DEF_WORD_LEN      = 32;
    localparam int unsigned REG_FILE_ADDR_LEN = 5;
    localparam int unsigned DEF_BASE_ADDR     = 1024;

    typedef enum logic {
        MEM_STATE_IDLE = 1'b0,
        MEM_STATE_BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data memory: synchronous write, asynchronous read.
module data_memory
    import mem_stage_pkg::*;
#(
    parameter int unsigned WORD_LEN  = DEF_WORD_LEN,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_DEPTH)-1:0] idx,
    input  logic [WORD_LEN-1:0]          wdata,
    output logic [WORD_LEN-1:0]          rdata
);

    logic [WORD_LEN-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: multi-cycle data memory access with upstream stall and MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned WORD_LEN   = DEF_WORD_LEN,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned BASE_ADDR  = DEF_BASE_ADDR,
    parameter int unsigned ACCESS_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         MEM_R_EN,
    input  logic                         MEM_W_EN,
    input  logic                         WB_EN_in,
    input  logic [REG_FILE_ADDR_LEN-1:0] dest_in,
    input  logic [WORD_LEN-1:0]          ALU_res,
    input  logic [WORD_LEN-1:0]          ST_value,
    output logic                         stall,
    output logic                         WB_EN_out,
    output logic                         MEM_R_EN_out,
    output logic [REG_FILE_ADDR_LEN-1:0] dest_out,
    output logic [WORD_LEN-1:0]          ALU_res_out,
    output logic [WORD_LEN-1:0]          mem_data_out,
    output logic                         addr_err
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam logic [2:0]  LAT   = 3'(ACCESS_LAT);

    mem_state_t          state;
    logic [2:0]          cnt;
    logic                req;
    logic                done;
    logic                in_range;
    logic                mem_we;
    logic [WORD_LEN-1:0] off;
    logic [WORD_LEN-1:0] rdata;
    logic [WORD_LEN-1:0] load_data;
    logic [IDX_W-1:0]    idx;

    always_comb begin
        req       = MEM_R_EN | MEM_W_EN;
        off       = ALU_res - WORD_LEN'(BASE_ADDR);
        idx       = off[2 +: IDX_W];
        in_range  = (ALU_res >= WORD_LEN'(BASE_ADDR)) && ((off >> 2) < WORD_LEN'(MEM_DEPTH));
        done      = req & ((LAT == 3'd0) | ((state == MEM_STATE_BUSY) & (cnt == 3'd0)));
        stall     = req & ~done;
        // Gating with rst drops a store whose completing edge coincides with reset.
        mem_we    = done & MEM_W_EN & in_range & ~rst;
        load_data = (MEM_R_EN & ~MEM_W_EN & in_range) ? rdata : '0;
    end

    data_memory #(
        .WORD_LEN  (WORD_LEN),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_data_memory (
        .clk   (clk),
        .we    (mem_we),
        .idx   (idx),
        .wdata (ST_value),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MEM_STATE_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MEM_STATE_IDLE: begin
                    if (req && (LAT != 3'd0)) begin
                        state <= MEM_STATE_BUSY;
                        cnt   <= LAT - 3'd1;
                    end
                end
                MEM_STATE_BUSY: begin
                    if (!req || done) begin
                        state <= MEM_STATE_IDLE;
                    end else if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= MEM_STATE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
            dest_out     <= '0;
            ALU_res_out  <= '0;
            mem_data_out <= '0;
            addr_err     <= 1'b0;
        end else if (stall) begin
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
            addr_err     <= 1'b0;
        end else begin
            WB_EN_out    <= WB_EN_in;
            MEM_R_EN_out <= MEM_R_EN & ~MEM_W_EN;
            dest_out     <= dest_in;
            ALU_res_out  <= ALU_res;
            mem_data_out <= load_data;
            addr_err     <= req & ~in_range;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage: three instances at ACCESS_LAT 2, 0 and 1.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        r_en    [3];
    logic        w_en    [3];
    logic        wb_in   [3];
    logic [4:0]  dst_in  [3];
    logic [31:0] alu_in  [3];
    logic [31:0] st_in   [3];
    logic        stall_o [3];
    logic        wb_o    [3];
    logic        mr_o    [3];
    logic [4:0]  dst_o   [3];
    logic [31:0] alu_o   [3];
    logic [31:0] data_o  [3];
    logic        err_o   [3];

    int          errors;
    int          checks;
    logic [31:0] model_mem [3][256];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_stage #(
            .WORD_LEN   (32),
            .MEM_DEPTH  (256),
            .BASE_ADDR  (1024),
            .ACCESS_LAT (g == 0 ? 2 : (g == 1 ? 0 : 1))
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .MEM_R_EN     (r_en[g]),
            .MEM_W_EN     (w_en[g]),
            .WB_EN_in     (wb_in[g]),
            .dest_in      (dst_in[g]),
            .ALU_res      (alu_in[g]),
            .ST_value     (st_in[g]),
            .stall        (stall_o[g]),
            .WB_EN_out    (wb_o[g]),
            .MEM_R_EN_out (mr_o[g]),
            .dest_out     (dst_o[g]),
            .ALU_res_out  (alu_o[g]),
            .mem_data_out (data_o[g]),
            .addr_err     (err_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    function automatic int unsigned lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 0 : 1);
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (lat=%0d): got %h expected %h", name, lat_of(d), got, exp);
        end
    endtask

    task automatic drive(input int d, input logic r, input logic w, input logic wb,
                         input logic [4:0] dst, input logic [31:0] a, input logic [31:0] s);
        r_en[d]   = r;
        w_en[d]   = w;
        wb_in[d]  = wb;
        dst_in[d] = dst;
        alu_in[d] = a;
        st_in[d]  = s;
    endtask

    // One full instruction: drive, wait out the stall, check the MEM/WB result, update the model.
    task automatic issue(input int d, input logic r, input logic w, input logic wb,
                         input logic [4:0] dst, input logic [31:0] a, input logic [31:0] s);
        bit          req;
        bit          inr;
        int unsigned idx;
        int unsigned n;
        logic [31:0] exp_data;
        req      = r | w;
        inr      = (a >= 32'd1024) && (((a - 32'd1024) >> 2) < 32'd256);
        idx      = inr ? ((a - 32'd1024) >> 2) : 0;
        exp_data = (r && !w && inr) ? model_mem[d][idx] : 32'h0;
        drive(d, r, w, wb, dst, a, s);
        #1;
        n = 0;
        while (stall_o[d] === 1'b1 && n < 16) begin
            @(posedge clk); #1;
            n++;
            checks++;
            if (wb_o[d] !== 1'b0 || mr_o[d] !== 1'b0 || err_o[d] !== 1'b0) begin
                errors++;
                $display("FAIL bubble (lat=%0d): got wb=%b mr=%b err=%b expected 0 0 0",
                         lat_of(d), wb_o[d], mr_o[d], err_o[d]);
            end
        end
        chk("stall_cycles", d, n, req ? lat_of(d) : 0);
        @(posedge clk); #1;
        chk("WB_EN_out", d, 32'(wb_o[d]), 32'(wb));
        chk("MEM_R_EN_out", d, 32'(mr_o[d]), 32'(r & ~w));
        chk("dest_out", d, 32'(dst_o[d]), 32'(dst));
        chk("ALU_res_out", d, alu_o[d], a);
        chk("mem_data_out", d, data_o[d], exp_data);
        chk("addr_err", d, 32'(err_o[d]), 32'(req & ~inr));
        if (w && inr) model_mem[d][idx] = s;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_stall", d, 32'(stall_o[d]), 0);
            chk("rst_wb", d, 32'(wb_o[d]), 0);
            chk("rst_alu", d, alu_o[d], 0);
            chk("rst_data", d, data_o[d], 0);
        end
    endtask

    task automatic test_reset_mid_access;
        issue(0, 0, 1, 0, 5'd0, 32'd1024, 32'hCAFE0000);
        drive(0, 0, 1, 1, 5'd9, 32'd1024, 32'h0000DEAD);
        #1;
        chk("mid_stall_idle", 0, 32'(stall_o[0]), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_wb", 0, 32'(wb_o[0]), 0);
        chk("mid_rst_dest", 0, 32'(dst_o[0]), 0);
        chk("mid_rst_alu", 0, alu_o[0], 0);
        chk("mid_rst_stall", 0, 32'(stall_o[0]), 0);
        issue(0, 1, 0, 1, 5'd2, 32'd1024, 32'h0);
    endtask

    task automatic test_store_load;
        issue(0, 0, 1, 0, 5'd0, 32'd1032, 32'h12345678);
        issue(0, 1, 0, 1, 5'd4, 32'd1032, 32'h0);
        chk("load_1032", 0, data_o[0], 32'h12345678);
        issue(0, 0, 0, 0, 5'd0, 32'd0, 32'h0);
    endtask

    task automatic test_lat0;
        logic [31:0] v;
        v = $urandom;
        issue(1, 0, 1, 0, 5'd0, 32'd1028, v);
        issue(1, 1, 0, 1, 5'd7, 32'd1028, 32'h0);
        chk("lat0_load", 1, data_o[1], v);
    endtask

    task automatic test_out_of_range;
        issue(0, 0, 1, 0, 5'd0, 32'd1024 + 4 * 255, 32'hA5A5A5A5);
        issue(0, 1, 0, 1, 5'd1, 32'd1020, 32'h0);
        issue(0, 0, 0, 0, 5'd0, 32'd0, 32'h0);
        issue(0, 1, 0, 1, 5'd1, 32'd1024 + 4 * 256, 32'h0);
        issue(0, 0, 0, 0, 5'd0, 32'd0, 32'h0);
        issue(0, 0, 1, 0, 5'd0, 32'd1020, 32'h11111111);
        issue(0, 1, 0, 1, 5'd1, 32'd1024 + 4 * 255, 32'h0);
        issue(0, 1, 0, 1, 5'd1, 32'd1024, 32'h0);
    endtask

    task automatic test_nonmem;
        issue(2, 0, 0, 1, 5'd3, 32'd7, 32'h0);
        chk("nonmem_alu", 2, alu_o[2], 32'd7);
    endtask

    task automatic test_both_and_abort;
        issue(2, 1, 1, 1, 5'd6, 32'd1036, 32'hBEEF0001);
        issue(2, 1, 0, 1, 5'd6, 32'd1036, 32'h0);
        drive(2, 0, 1, 0, 5'd0, 32'd1036, 32'h0BAD0BAD);
        @(posedge clk); #1;
        drive(2, 0, 0, 0, 5'd0, 32'd1036, 32'h0BAD0BAD);
        #1;
        chk("abort_stall", 2, 32'(stall_o[2]), 0);
        @(posedge clk); #1;
        issue(2, 1, 0, 1, 5'd6, 32'd1036, 32'h0);
    endtask

    task automatic test_random;
        logic [31:0] a;
        int unsigned op;
        int unsigned sel;
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 8; k++) issue(d, 0, 1, 0, 5'd0, 32'd1024 + 4 * k, $urandom);
            for (int i = 0; i < 40; i++) begin
                op  = $urandom_range(0, 3);
                sel = $urandom_range(0, 9);
                case (sel)
                    8:       a = 32'd1020;
                    9:       a = 32'd2048 + $urandom_range(0, 64);
                    default: a = 32'd1024 + 4 * sel + $urandom_range(0, 3);
                endcase
                issue(d, op[0], op[1], 1'($urandom), 5'($urandom), a, $urandom);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 0, 0, 0, 0, 0, 0);
        test_reset;
        test_reset_mid_access;
        test_store_load;
        test_lat0;
        test_out_of_range;
        test_nonmem;
        test_both_and_abort;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
